// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
package i2s_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SLOT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for one asynchronous input, plus a delayed copy
// used to derive single-cycle rise and any-edge pulses.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic any_edge
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Synchronizer chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~dly_q;
  assign any_edge = sync_q ^ dly_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples SCLK/LRCLK/SDATA on clk, aligns to LRCLK
// slots and presents the top DATA_W bits of each slot as a signed word
// with a channel tag that only changes together with sample_valid.
//
//   state | meaning
//   IDLE  | after reset; waiting for the first LRCLK edge
//   SKIP  | slot started; next SCLK rise carries previous word's LSB
//   SHIFT | capturing DATA_W bits MSB first
//   HOLD  | word complete; ignoring remaining slot bits
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_sclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_lr,
  output logic              sample_valid,
  output logic              frame_err
);

  // Counter is sized for a full slot so a mis-set DATA_W cannot wrap it.
  localparam int CNT_W = $clog2(SLOT_W + 1);

  logic sclk_rise;
  logic sclk_sync_unused;
  logic sclk_edge_unused;
  logic lrclk_sync;
  logic lr_edge;
  logic lrclk_rise_unused;
  logic sdata_sync;
  logic sdata_rise_unused;
  logic sdata_edge_unused;

  sync_edge_detect u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (i2s_sclk),
    .sync_out (sclk_sync_unused),
    .rise     (sclk_rise),
    .any_edge (sclk_edge_unused)
  );

  sync_edge_detect u_sync_lrclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (i2s_lrclk),
    .sync_out (lrclk_sync),
    .rise     (lrclk_rise_unused),
    .any_edge (lr_edge)
  );

  sync_edge_detect u_sync_sdata (
    .clk      (clk),
    .reset    (reset),
    .async_in (i2s_sdata),
    .sync_out (sdata_sync),
    .rise     (sdata_rise_unused),
    .any_edge (sdata_edge_unused)
  );

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              cur_ch;
  logic              word_done;

  logic              shift_en;
  logic              cnt_clr;
  logic              latch_ch;
  logic              err_d;
  logic              done_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls. An LRCLK edge always wins over a
  // coincident SCLK rise; that rise is then consumed as the skip bit.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    latch_ch = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;

    if (lr_edge) begin
      latch_ch = 1'b1;
      cnt_clr  = 1'b1;
      state_d  = sclk_rise ? SHIFT : SKIP;
      if (state_q == SKIP || state_q == SHIFT) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SKIP: begin
          if (sclk_rise) begin
            cnt_clr = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              done_d  = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Shift register, bit counter and channel latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      cur_ch  <= 1'b0;
    end else begin
      if (latch_ch) begin
        cur_ch <= lrclk_sync;
      end
      if (cnt_clr) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        shift_q <= {shift_q[DATA_W-2:0], sdata_sync};
      end
    end
  end

  // Output stage: word and channel tag move together with the valid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_done    <= 1'b0;
      sample_out   <= '0;
      sample_lr    <= 1'b0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      word_done    <= done_d;
      sample_valid <= word_done;
      frame_err    <= err_d;
      if (word_done) begin
        sample_out <= shift_q;
        sample_lr  <= cur_ch;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for the I2S receiver: drives I2S slots at SCLK = clk/10 and
// compares captured words against a slot-level reference model.
module tb_i2s_rx_deserializer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i2s_sclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic [DW-1:0] sample_out;
  logic          sample_lr;
  logic          sample_valid;
  logic          frame_err;

  always #5 clk = ~clk;

  i2s_rx_deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_out   (sample_out),
    .sample_lr    (sample_lr),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Observed traffic.
  logic [DW:0] got_q[$];
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  longint      t_rise    = 0;
  longint      max_lat   = 0;

  // Reference model state: slot-level view of the link.
  logic [DW:0] exp_q[$];
  int          exp_err   = 0;
  int          exp_total = 0;
  logic        lr_level  = 1'b0;
  logic        pending   = 1'b0;
  logic        ready     = 1'b0;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_q.push_back({sample_lr, sample_out});
      valid_cnt++;
      if (($time - 5 - t_rise) > max_lat) max_lat = $time - 5 - t_rise;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One SCLK period: data and LRCLK change on the falling edge.
  task automatic drive_period(input logic lr, input logic d, input bit mark);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = d;
    #50;
    i2s_sclk = 1'b1;
    if (mark) t_rise = $time;
    #50;
  endtask

  // One slot of len SCLK periods. word holds the slot bits MSB first,
  // left-justified. Period 0 carries the previous slot's last bit.
  task automatic send_slot(input logic ch, input logic [31:0] word, input int len, input bit rst_mid);
    logic d;
    bit   edge_seen;
    edge_seen = (ch != lr_level);
    for (int i = 0; i < len; i++) begin
      d = (i == 0) ? pending : word[32-i];
      if (rst_mid && i == 0) reset = 1'b0;
      if (rst_mid && i == 8) reset = 1'b1;
      drive_period(ch, d, i == DW);
    end
    pending  = word[32-len];
    lr_level = ch;
    if (rst_mid) begin
      ready = 1'b0;
    end else begin
      if (edge_seen) ready = 1'b1;
      if (ready) begin
        if (len - 1 >= DW) begin
          exp_q.push_back({ch, word[31:32-DW]});
          exp_total++;
        end else begin
          exp_err++;
        end
      end
    end
  endtask

  task automatic check_queues(input string tag);
    logic [DW:0] e;
    logic [DW:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk({tag, "_word"}, 32'(g), 32'(e));
    end
    chk({tag, "_extra_pulses"}, got_q.size(), 0);
    chk({tag, "_frame_err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin
    logic [31:0] w;
    logic        ch;
    int          len;
    int          r;

    // Reset held with lines toggling.
    reset     = 1'b0;
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i2s_sclk  = 1'($urandom);
      i2s_lrclk = 1'($urandom);
      i2s_sdata = 1'($urandom);
      @(negedge clk);
      chk("rst_out", {11'b0, sample_lr, sample_valid, frame_err, 2'b0, sample_out}, 32'h0);
    end
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // SCLK running but no LRCLK edge: nothing may come out.
    for (int i = 0; i < 40; i++) drive_period(1'b0, 1'($urandom), 1'b0);
    chk("no_lr_edge_valid", valid_cnt, 0);
    chk("no_lr_edge_err", err_cnt, 0);

    // First right slot arms the receiver, then left 0x8001.
    send_slot(1'b1, $urandom, 32, 1'b0);
    send_slot(1'b0, 32'h8001_0000, 32, 1'b0);
    chk("left_8001_out", 32'(sample_out), 32'h8001);
    chk("left_8001_lr", 32'(sample_lr), 0);
    chk("left_8001_latency", 32'(max_lat <= 50), 1);
    check_queues("left_8001");

    // Right slot with a 24-bit word.
    send_slot(1'b1, 32'h1234_5600, 32, 1'b0);
    chk("right_24b_out", 32'(sample_out), 32'h1234);
    chk("right_24b_lr", 32'(sample_lr), 1);
    check_queues("right_24b");

    // Short slot: 10 data bits then LRCLK toggles.
    send_slot(1'b0, $urandom, 11, 1'b0);
    chk("short_hold_out", 32'(sample_out), 32'h1234);
    chk("short_hold_lr", 32'(sample_lr), 1);
    send_slot(1'b1, $urandom, 32, 1'b0);
    check_queues("after_short");

    // Reset released at bit 7 of a left word.
    send_slot(1'b0, $urandom, 32, 1'b1);
    chk("midrst_out", 32'(sample_out), 0);
    chk("midrst_lr", 32'(sample_lr), 0);
    check_queues("midrst");
    send_slot(1'b1, $urandom, 32, 1'b0);
    check_queues("after_midrst");

    // Biquad-style pair.
    send_slot(1'b0, 32'h2000_0000, 32, 1'b0);
    chk("pair_2000_out", 32'(sample_out), 32'h2000);
    send_slot(1'b1, 32'hE000_0000, 32, 1'b0);
    chk("pair_e000_out", 32'(sample_out), 32'hE000);
    chk("pair_e000_lr", 32'(sample_lr), 1);
    check_queues("pair");

    // Random slots: mostly full, some long-enough partial, some short.
    ch = 1'b0;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      len = 32;
      else if (r < 8) len = $urandom_range(DW + 1, 31);
      else            len = $urandom_range(4, DW);
      w = $urandom;
      send_slot(ch, w, len, 1'b0);
      ch = ~ch;
    end
    send_slot(ch, $urandom, 32, 1'b0);
    send_slot(~ch, $urandom, 32, 1'b0);
    check_queues("random");
    chk("pulse_count", valid_cnt, exp_total);
    chk("max_latency", 32'(max_lat <= 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
Front-end stage that receives the serial I2S stream from the audio ADC and produces parallel 16-bit two's-complement samples for the time-multiplexed biquad. The block oversamples SCLK, LRCLK and SDATA on the fast system clock and aligns to the LRCLK frame. It presents each completed word with a channel tag whose level changes only when a new sample is valid. The biquad's any-edge detector on the channel tag therefore latches exactly one new sample per channel slot.

Parameters:
DATA_W, 16, bits captured per word, MSB first; also the width of sample_out.
SLOT_W, 32, SCLK periods per LRCLK half-frame; must be at least DATA_W+1.

Ports:
clk  in  1  system clock; must run at 8x the SCLK frequency or faster.
reset  in  1  synchronous, active-low.
i2s_sclk  in  1  bit clock from ADC; asynchronous to clk.
i2s_lrclk  in  1  word select: 0 = left, 1 = right; asynchronous.
i2s_sdata  in  1  serial data, valid at SCLK rising edge; asynchronous.
sample_out  out  DATA_W  last completed word, signed.
sample_lr  out  1  channel of sample_out; drives the biquad l_r_clk.
sample_valid  out  1  one-cycle pulse when sample_out and sample_lr update.
frame_err  out  1  one-cycle pulse when a slot ends before DATA_W bits are captured.

Behaviour:
- Reset (reset=0 at a clk edge): sample_out=0, sample_lr=0, sample_valid=0, frame_err=0, bit_cnt=0, shift register=0, state=IDLE. Synchronizer flops clear to 0.
- Synchronization: all three inputs pass through 2-flop synchronizers. A third register on SCLK and LRCLK gives sclk_rise and lr_edge single-cycle pulses (lr_edge fires on either edge). SDATA is sampled from its synchronized copy in the sclk_rise cycle.
- States:
  - IDLE: ignore everything until lr_edge, then go to SKIP. This discards any partial slot after reset.
  - SKIP: the first sclk_rise after lr_edge carries the previous word's LSB and is discarded. Then bit_cnt=0 and the state goes to SHIFT.
  - SHIFT: on each sclk_rise, shift SDATA in at the LSB and increment bit_cnt. When bit_cnt reaches DATA_W, go to HOLD.
  - HOLD: ignore the remaining slot bits (truncates 24/32-bit ADC words to the top DATA_W bits). On lr_edge, go to SKIP.
- Channel latch: at every lr_edge, latch cur_ch = synchronized LRCLK level.
- Output update: on the cycle after the DATA_W-th bit is shifted in:
  - sample_out <= shift register;
  - sample_lr <= cur_ch;
  - sample_valid <= 1 for that one cycle only.
  - sample_out and sample_lr hold until the next valid word.
- Latency: sample_valid asserts no more than 5 clk cycles after the SCLK pin edge that carries the last captured bit.
- lr_edge in SHIFT (short slot): pulse frame_err for one cycle, do not assert sample_valid, discard the partial word, latch the new cur_ch and go to SKIP. Outputs keep their previous values.
- lr_edge in SKIP: restart SKIP with the new channel and pulse frame_err.
- lr_edge and sclk_rise in the same cycle: process lr_edge first. The coincident rise counts as the SKIP bit.
- Reset mid-word: the partial word is lost with no valid pulse. After release, the block re-enters IDLE and waits for a fresh lr_edge.
- Arithmetic: none. Bits pass unchanged and MSB-first; no sign conversion or rounding.

Decomposition:
- Package i2s_pkg: rx_state_t enum (IDLE, SKIP, SHIFT, HOLD) and localparams for default DATA_W/SLOT_W.
- Sub-module sync_edge_detect: 2-flop synchronizer plus delayed copy. Outputs sync, rise and any-edge. Instantiated for SCLK and LRCLK; SDATA uses the sync output only.

Test Plan:
1. Hold reset=0 for 5 clk with the I2S lines toggling -> all outputs 0 and no pulses; no output until the first LRCLK edge after release.
2. Left slot (LRCLK=0, SLOT_W=32) carrying 0x8001 -> exactly one sample_valid, sample_out=0x8001, sample_lr=0, within 5 clk of the 17th SCLK rise after the LRCLK edge; frame_err stays 0.
3. Following right slot carrying 24-bit 0x123456 -> sample_out=0x1234, sample_lr=1, one valid pulse. Over 1000 alternating frames, pulse count equals slot count.
4. LRCLK toggles after only 10 bits of a word -> one frame_err pulse, no sample_valid, sample_out keeps its prior value. The next full slot is captured correctly.
5. Release reset mid-slot (bit 7 of a left word) -> that word is discarded. The first valid word is the next complete slot, with the correct value and channel.
6. Connect to the biquad with b0=0x4000 and the other coefficients 0, feeding 0x2000 then 0xE000 -> the biquad's filtered_output follows 0x2000 then 0xE000. Exactly one biquad computation per sample_valid.
